// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: access-size encodings and data-memory constants shared with the memory stage.
package data_mem_responder_pkg;
  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } mem_access_size_t;
  localparam logic [63:0] DATA_MEM_BASE  = 64'h0000_0000_8000_0000;
  localparam int          DATA_MEM_DEPTH = 4096;
  // First byte lane touched by a naturally aligned access of the given size.
  function automatic logic [2:0] lane_base(input logic [2:0] a, input mem_access_size_t s);
    return s == BYTE ? a : s == HALF_WORD ? {a[2:1], 1'b0} : s == WORD ? {a[2], 2'b00} : 3'd0;
  endfunction
endpackage

// File: rtl/data_mem_responder_store_align.sv
// mem_store_align: turns a right-justified store into a byte-lane mask and lane-aligned data.
module mem_store_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]       addr_i,
  input  mem_access_size_t size_i,
  input  logic [63:0]      data_i,
  output logic [7:0]       lane_mask_o,
  output logic [63:0]      data_aligned_o
);
  logic [2:0] base;
  logic [7:0] span;
  always_comb begin
    base           = lane_base(addr_i, size_i);
    span           = size_i == BYTE ? 8'h01 : size_i == HALF_WORD ? 8'h03 : size_i == WORD ? 8'h0F : 8'hFF;
    lane_mask_o    = span << base;
    data_aligned_o = data_i << {base, 3'b000};
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-write block-RAM data memory answering one request per handshake,
// responses returned in order through a small FIFO with a bypass path from the read stage.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = DATA_MEM_DEPTH,
  parameter logic [63:0] BASE_ADDR   = DATA_MEM_BASE,
  parameter int          RESP_DEPTH  = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_i,
  input  logic [63:0]      addr_i,
  input  mem_access_size_t byte_en_i,
  input  logic             wr_i,
  input  logic [63:0]      wr_data_i,
  output logic             ready_o,
  output logic             resp_valid_o,
  output logic [63:0]      rd_data_o,
  input  logic             rd_ready_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1) + 1;

  (* ram_style = "block" *) logic [63:0] mem [DEPTH_WORDS];
  logic [63:0]   fifo_mem [RESP_DEPTH];
  logic [63:0]   ram_q, s1_data, data_aligned;
  logic [7:0]    lane_mask;
  logic [AW-1:0] idx;
  logic          unused_addr;
  logic          accept, fifo_empty, push, pop, fifo_pop;
  logic          s1_valid_q, s1_valid_d, s1_is_wr_q, s1_is_wr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(RESP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  mem_store_align u_align (
    .addr_i        (addr_i[2:0]),
    .size_i        (byte_en_i),
    .data_i        (wr_data_i),
    .lane_mask_o   (lane_mask),
    .data_aligned_o(data_aligned)
  );

  always_comb begin
    // Base is doubleword aligned, so only the index bits of the subtraction matter; upper bits wrap.
    idx          = addr_i[AW+2:3] - BASE_ADDR[AW+2:3];
    unused_addr  = ^addr_i[63:AW+3];
    ready_o      = (count_q + CW'(s1_valid_q)) < CW'(RESP_DEPTH);
    accept       = req_i & ready_o;
    fifo_empty   = count_q == '0;
    s1_data      = s1_is_wr_q ? '0 : ram_q;
    resp_valid_o = !fifo_empty | s1_valid_q;
    rd_data_o    = !fifo_empty ? fifo_mem[rd_ptr_q] : s1_valid_q ? s1_data : '0;
    pop          = resp_valid_o & rd_ready_i;
    fifo_pop     = pop & !fifo_empty;
    // s1 queues behind older entries, or when the consumer stalls.
    push         = s1_valid_q & (!fifo_empty | !rd_ready_i);
    s1_valid_d   = accept;
    s1_is_wr_d   = accept & wr_i;
    wr_ptr_d     = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = fifo_pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (accept & wr_i)
      for (int b = 0; b < 8; b++)
        if (lane_mask[b]) mem[idx][8*b +: 8] <= data_aligned[8*b +: 8];
    if (accept & !wr_i) ram_q <= mem[idx];
  end

  always_ff @(posedge clk) if (push) fifo_mem[wr_ptr_q] <= s1_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_is_wr_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_is_wr_q <= s1_is_wr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random load/store traffic against a byte-array memory model
// and an in-order queue of expected responses.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;
  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic             clk = 0, resetn = 0, req_i = 0, wr_i = 0, rd_ready_i = 0;
  logic [63:0]      addr_i = '0, wr_data_i = '0;
  mem_access_size_t byte_en_i = BYTE;
  logic             ready_o, resp_valid_o;
  logic [63:0]      rd_data_o;

  int          total = 0, bad = 0, n_acc = 0, n_pop = 0;
  logic [63:0] last_rsp = '0;
  logic [63:0] exp_q[$];
  logic [7:0]  bm [32768];

  data_mem_responder dut (
    .clk(clk), .resetn(resetn), .req_i(req_i), .addr_i(addr_i), .byte_en_i(byte_en_i),
    .wr_i(wr_i), .wr_data_i(wr_data_i), .ready_o(ready_o), .resp_valid_o(resp_valid_o),
    .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i)
  );

  always #5 clk = ~clk;

  function automatic int offs(input logic [63:0] a);
    return int'((a - B) & 64'h7FFF);
  endfunction

  function automatic logic [63:0] ld(input logic [63:0] a);
    int o = offs(a) & ~7;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = bm[o + i];
    return r;
  endfunction

  task automatic st(input logic [63:0] a, input mem_access_size_t sz, input logic [63:0] d);
    int n = 1 << int'(sz);
    int o = offs(a) & ~(n - 1);
    for (int i = 0; i < n; i++) bm[o + i] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance past the edge.
  task automatic cyc(input logic req, input logic [63:0] a, input mem_access_size_t sz,
                     input logic wr, input logic [63:0] d, input logic rdy);
    req_i = req; addr_i = a; byte_en_i = sz; wr_i = wr; wr_data_i = d; rd_ready_i = rdy;
    chk("resp_valid", 64'(resp_valid_o), 64'(exp_q.size() != 0));
    chk("ready", 64'(ready_o), 64'(exp_q.size() < 2));
    if (!resp_valid_o) chk("idle_data", rd_data_o, 64'h0);
    if (resp_valid_o && rdy && exp_q.size() != 0) begin
      chk("rd_data", rd_data_o, exp_q.pop_front());
      last_rsp = rd_data_o;
      n_pop++;
    end
    if (req && ready_o) begin
      exp_q.push_back(wr ? 64'h0 : ld(a));
      if (wr) st(a, sz, d);
      n_acc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 64'h0, BYTE, 1'b0, 64'h0, rdy);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(resp_valid_o), 64'h0);
    chk("rst_data", rd_data_o, 64'h0);
    chk("rst_ready", 64'(ready_o), 64'h1);
    resetn = 1;
    @(posedge clk); #1;

    cyc(1, B, DOUBLE_WORD, 1, 64'h1122334455667788, 1);
    cyc(1, B, DOUBLE_WORD, 0, 64'h0, 1);
    idle(1);
    chk("sd_ld", last_rsp, 64'h1122334455667788);
    cyc(1, B + 5, BYTE, 1, 64'hFFFF_FFFF_FFFF_FFAB, 1);
    cyc(1, B, DOUBLE_WORD, 0, 64'h0, 1);
    idle(1);
    chk("sb_ld", last_rsp, 64'h1122AB4455667788);
    cyc(1, B + 2, HALF_WORD, 1, 64'h5555_5555_5555_BEEF, 1);
    cyc(1, B, DOUBLE_WORD, 0, 64'h0, 1);
    idle(1);
    chk("sh_ld", last_rsp, 64'h1122AB44BEEF7788);
    cyc(1, B + 8, DOUBLE_WORD, 1, 64'h0123456789ABCDEF, 1);
    cyc(1, B + 12, WORD, 1, 64'h7777_7777_DEAD_BEEF, 1);
    cyc(1, B + 8, DOUBLE_WORD, 0, 64'h0, 1);
    idle(1);
    chk("sw_ld", last_rsp, 64'hDEADBEEF89ABCDEF);

    for (int i = 2; i < 8; i++) cyc(1, B + 64'(8 * i), DOUBLE_WORD, 1, {$urandom, $urandom}, 1);
    idle(1);

    n_acc = 0;
    repeat (5) cyc(1, B, DOUBLE_WORD, 0, 64'h0, 0);
    chk("bp_accepted", 64'(n_acc), 64'd2);
    n_pop = 0;
    repeat (3) idle(1);
    chk("bp_popped", 64'(n_pop), 64'd2);

    n_acc = 0;
    for (int i = 0; i < 16; i++) cyc(1, B + 64'(8 * (i % 8)), DOUBLE_WORD, 0, 64'h0, 1);
    idle(1);
    chk("burst_accepted", 64'(n_acc), 64'd16);

    cyc(1, B, DOUBLE_WORD, 0, 64'h0, 0);
    cyc(1, B + 8, DOUBLE_WORD, 0, 64'h0, 0);
    req_i = 0;
    resetn = 0;
    #1;
    chk("midrst_valid", 64'(resp_valid_o), 64'h0);
    chk("midrst_data", rd_data_o, 64'h0);
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1;
    chk("midrst_ready", 64'(ready_o), 64'h1);
    cyc(1, B, DOUBLE_WORD, 0, 64'h0, 1);
    idle(1);
    chk("persist", last_rsp, 64'h1122AB44BEEF7788);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] a;
      int          al = int'($urandom % 3);
      a = (al == 0 ? B : al == 1 ? B + 64'h8000 : B - 64'h8000) + 64'($urandom % 64);
      cyc($urandom % 4 != 0, a, mem_access_size_t'($urandom % 4), $urandom % 2 == 1,
          {$urandom, $urandom}, $urandom % 4 != 0);
    end
    repeat (4) idle(1);
    chk("drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
